nibble_parity_tx: RTL and testbench

Serial transmit stage for 4-bit data words protected by even parity. It accepts a nibble over a valid/ready handshake and computes the even-parity bit internally. It then shifts out a 7-bit frame on a single line: start, 4 data bits LSB-first, parity, stop. It sits directly downstream of the team's 4-bit parity generation logic and turns its nibble+parity result into a line-level bitstream.

---
 rtl/nibble_tx_pkg.sv | 14 +
 rtl/nibble_parity_tx_parity.sv | 9 +
 rtl/nibble_parity_tx.sv | 128 ++++++++++++
 tb/tb_nibble_parity_tx.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/nibble_tx_pkg.sv
// Shared types and constants for the nibble serial transmit path.
package nibble_tx_pkg;
  localparam int   DATA_W     = 4;
  localparam int   FRAME_BITS = 7;     // start + 4 data + parity + stop
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;
endpackage

// File: rtl/nibble_parity_tx_parity.sv
// Even-parity generator: XOR reduction of a nibble.
module even_parity4
  import nibble_tx_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic              parity_o
);
  assign parity_o = ^data_i;
endmodule

// File: rtl/nibble_parity_tx.sv
// Serial transmitter: start, 4 data bits LSB-first, even parity, stop.
module nibble_parity_tx
  import nibble_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  localparam int            CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  tx_state_t         state_q, state_d;
  logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
  logic [1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              par_w;
  logic              accept;
  logic              bit_end;

  even_parity4 u_par (
    .data_i   (in_data),
    .parity_o (par_w)
  );

  assign accept  = in_valid && rdy_q;
  assign bit_end = (clk_cnt_q == CNT_MAX);

  // Next-state logic. tx is computed from the state being entered so the
  // line changes on the same edge as the state, keeping every output registered.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    tx_d      = tx_q;
    rdy_d     = rdy_q;
    done_d    = 1'b0;
    if (state_q != IDLE) clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (accept) begin
          state_d   = START;
          rdy_d     = 1'b0;
          shreg_d   = in_data;
          par_d     = par_w;
          tx_d      = 1'b0;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      START: if (bit_end) begin
        state_d   = DATA;
        bit_cnt_d = '0;
        tx_d      = shreg_q[0];
        shreg_d   = shreg_q >> 1;
      end
      DATA: if (bit_end) begin
        bit_cnt_d = bit_cnt_q + 2'd1;   // wraps 3->0 on leaving DATA
        if (bit_cnt_q == 2'd3) begin
          state_d = PARITY;
          tx_d    = par_q;
        end else begin
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      PARITY: if (bit_end) begin
        state_d = STOP;
        tx_d    = IDLE_LEVEL;
      end
      STOP: if (bit_end) begin
        state_d = IDLE;
        tx_d    = IDLE_LEVEL;
        rdy_d   = 1'b1;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LEVEL;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= IDLE_LEVEL;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign in_ready = rdy_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_nibble_parity_tx.sv
// Directed bench for nibble_parity_tx at CLKS_PER_BIT=4 and 1.
module tb_nibble_parity_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;        // 0: CLKS_PER_BIT=4 instance, 1: CLKS_PER_BIT=1
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       in_valid4, in_valid1;
  logic       tx4, rdy4, busy4, done4;
  logic       tx1, rdy1, busy1, done1;
  logic       tx_s, rdy_s, busy_s, done_s;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int start_cyc = 0;
  int prev_start = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign in_valid4 = in_valid & ~sel;
  assign in_valid1 = in_valid & sel;
  assign tx_s   = sel ? tx1   : tx4;
  assign rdy_s  = sel ? rdy1  : rdy4;
  assign busy_s = sel ? busy1 : busy4;
  assign done_s = sel ? done1 : done4;

  nibble_parity_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid4),
    .in_ready(rdy4), .tx(tx4), .busy(busy4), .done(done4)
  );

  nibble_parity_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid1),
    .in_ready(rdy1), .tx(tx1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer d, check the whole frame f (f[0] sent first); ends in the done cycle.
  task automatic send(input logic [3:0] d, input logic [0:6] f, input int cpb,
                      input bit hold, input logic [3:0] after);
    in_data  = d;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !rdy_s; k++) tick;
    chk("ready_wait", rdy_s, 1);
    tick;                                  // accept edge
    if (!hold) in_valid = 1'b0;
    in_data    = after;
    prev_start = start_cyc;
    start_cyc  = cyc;
    for (int b = 0; b < 7; b++) begin
      for (int c = 0; c < cpb; c++) begin
        chk($sformatf("tx_d%0h_b%0d_c%0d", d, b, c), tx_s, f[b]);
        chk("busy_in_frame", busy_s, 1);
        chk("done_in_frame", done_s, 0);
        chk("ready_in_frame", rdy_s, 0);
        tick;
      end
    end
    chk("done_pulse", done_s, 1);
    chk("ready_back", rdy_s, 1);
    chk("busy_end", busy_s, 0);
    chk("tx_idle_end", tx_s, 1);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", tx4, 1);
    chk("rst_ready", rdy4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_tx_1", tx1, 1);
    rst_n = 1'b1;
    chk("ready_before_edge", rdy4, 0);
    tick;
    chk("ready_after_release", rdy4, 1);
    chk("ready_after_release_1", rdy1, 1);

    // basic frame
    send(4'b1011, 7'b0110111, 4, 1'b0, 4'b1011);
    tick;
    chk("done_one_cycle", done_s, 0);

    // all zeros, data changed right after accept
    send(4'b0000, 7'b0000001, 4, 1'b0, 4'hF);
    tick;
    chk("done_one_cycle_0", done_s, 0);
    tick;

    // back-to-back with in_valid held
    send(4'hF, 7'b0111101, 4, 1'b1, 4'h1);
    send(4'h1, 7'b0100011, 4, 1'b0, 4'h0);
    chk("b2b_spacing", start_cyc - prev_start, 29);
    tick;
    chk("done_one_cycle_b2b", done_s, 0);

    // reset mid-frame
    in_data  = 4'h5;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !rdy_s; k++) tick;
    chk("ready_wait_5", rdy_s, 1);
    tick;
    in_valid = 1'b0;
    repeat (10) tick;
    chk("mid_tx_d1", tx_s, 0);
    chk("mid_busy", busy_s, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_tx", tx_s, 1);
    chk("async_ready", rdy_s, 0);
    chk("async_busy", busy_s, 0);
    chk("async_done", done_s, 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("rst_hold_done", done_s, 0);
    end
    rst_n = 1'b1;
    chk("ready_low_release", rdy_s, 0);
    tick;
    chk("ready_high_release", rdy_s, 1);
    chk("no_done_after_abort", done_s, 0);
    chk("tx_idle_after_abort", tx_s, 1);
    send(4'h3, 7'b0110001, 4, 1'b0, 4'h3);
    tick;

    // single clock per bit
    sel = 1'b1;
    #1;
    chk("cpb1_ready", rdy_s, 1);
    send(4'h6, 7'b0011001, 1, 1'b0, 4'h6);
    tick;
    chk("cpb1_done_one_cycle", done_s, 0);
    chk("cpb4_idle", tx4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
